// File: rtl/shift_pkg.sv
// Shared widths and FSM encoding for the shift unit (expander/extractor pair).
package shift_pkg;

   localparam int IN_W      = 64;
   localparam int OUT_W     = 32;
   localparam int IDX_W     = 7;
   localparam int MAX_SHIFT = 32;

   // One iteration per shift_index bit 0..5; bit 6 only matters for rejected indices.
   localparam int STEP_W    = 3;
   localparam int LAST_STEP = 5;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } shx_state_t;

endpackage

// File: rtl/shift_stage.sv
// One log-shifter stage: shifts right by 2**k when amt_bit is set, zeros enter from the MSB.
module shift_stage
   import shift_pkg::*;
(
   input  logic [IN_W-1:0]   data_in,
   input  logic              amt_bit,
   input  logic [STEP_W-1:0] k,
   output logic [IN_W-1:0]   data_out
);

   logic [IDX_W-1:0] amount;

   always_comb begin
      amount   = IDX_W'(1) << k;
      data_out = amt_bit ? (data_in >> amount) : data_in;
   end

endmodule

// File: rtl/shift_extractor.sv
// Recovers a 32-bit operand placed at bit offset shift_index inside a 64-bit word,
// using one shared log-shifter stage iterated over the index bits.
module shift_extractor
   import shift_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_W-1:0]   input_b,
   input  logic [IDX_W-1:0]  shift_index,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  output_a,
   output logic              out_err,
   output shx_state_t        dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
   // in_ready is high only in IDLE, out_valid only in DONE; output_a/out_err stay stable
   // while out_valid is high and out_ready is low.

   shx_state_t        state_q, state_d;
   logic [IN_W-1:0]   data_q;
   logic [IDX_W-1:0]  idx_q;
   logic [STEP_W-1:0] step_q;
   logic              err_q;
   logic [IN_W-1:0]   stage_out;
   logic              accept;
   logic              last_step;

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign dbg_state = state_q;
   assign accept    = in_valid && in_ready;
   assign last_step = (step_q == STEP_W'(LAST_STEP));

   shift_stage u_stage (
      .data_in  (data_q),
      .amt_bit  (idx_q[step_q]),
      .k        (step_q),
      .data_out (stage_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // A rejected index still spends one SHIFT cycle so its result appears one edge after accept.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_SHIFT;
         S_SHIFT: if (err_q || last_step) state_d = S_DONE;
         S_DONE:  if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q   <= '0;
         idx_q    <= '0;
         step_q   <= '0;
         err_q    <= 1'b0;
         output_a <= '0;
         out_err  <= 1'b0;
      end else if (accept) begin
         data_q <= input_b;
         idx_q  <= shift_index;
         step_q <= '0;
         err_q  <= (shift_index > IDX_W'(MAX_SHIFT));
      end else if (state_q == S_SHIFT) begin
         if (err_q) begin
            output_a <= '0;
            out_err  <= 1'b1;
         end else begin
            data_q <= stage_out;
            step_q <= step_q + STEP_W'(1);
            if (last_step) begin
               output_a <= stage_out[OUT_W-1:0];
               out_err  <= 1'b0;
            end
         end
      end
   end

endmodule
